tl_a_arbiter: RTL and testbench
===============================

TL_A_ARBITER -- requirements
Module: tl_a_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, which sets the A-channel address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, which sets the data width; the mask is DATA_W/8 bits wide.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in0_a_{ready,valid,bits_opcode[3],bits_size[4],bits_address[ADDR_W],bits_mask,bits_data[DATA_W]}: requester 0 A channel (ready is an output, the rest are inputs).
REQ-006 in1_a_*: requester 1 A channel, with the same fields as in0_a_*.
REQ-007 in{0,1}_d_{ready in; valid,bits_opcode[3],bits_param[2],bits_size[4],bits_sink[3],bits_denied,bits_data,bits_corrupt out}: per-requester D channel.
REQ-008 out_a_*: shared A channel toward the slave; it carries the in*_a fields plus out_a_bits_source[1] (the requester index).
REQ-009 out_d_*: shared D channel from the slave; it carries the in*_d fields plus out_d_bits_source[1].

Function
REQ-010 The A path SHALL be combinational from the granted input to out_a, with zero added latency.
REQ-011 Beats per message SHALL be 2^(size-log2(DATA_W/8)) for PutFull (0) and PutPartial (1) when size exceeds log2(DATA_W/8); every other message SHALL be 1 beat.
REQ-012 The state machine SHALL have the states IDLE, HOLD and BURST.
REQ-013 In IDLE, the grant SHALL be chosen combinationally from the valid inputs according to the REQ-024/025 policy.
REQ-014 In IDLE, if out_a_valid and !out_a_ready, the FSM SHALL move to HOLD and freeze the grant, so that valid and bits stay stable until the handshake.
REQ-015 In HOLD, the grant SHALL be held, and the FSM SHALL leave HOLD only on an out_a fire.
REQ-016 On the first-beat fire of a multi-beat message, the FSM SHALL load beats-1 into the beat counter and enter BURST; for a single-beat message it SHALL return to IDLE.
REQ-017 In BURST, the grant SHALL be locked, the counter SHALL decrement on each fire, and the FSM SHALL return to IDLE on the fire at counter==1.
REQ-018 The non-granted input's a_ready SHALL be 0, and the granted input's a_ready SHALL equal out_a_ready.
REQ-019 out_a_bits_source SHALL equal the grant index.
REQ-020 D routing: out_d_valid SHALL be steered to in[out_d_bits_source]_d_valid, out_d_ready SHALL equal that input's d_ready, and the D bits SHALL be broadcast to both inputs.
REQ-021 A and D SHALL be independent; a D beat in the same cycle as an A fire SHALL be legal, with no interaction.
REQ-022 When both inputs are valid on the cycle a burst ends, re-arbitration SHALL occur in the following cycle, with the pointer already updated.
REQ-023 The round-robin pointer SHALL update only on the final-beat fire of a message, to the index opposite the winner.

Configuration
REQ-024 With TL_ARB_RR_EN defined, arbitration SHALL be round-robin: the pointer's input has priority, and the pointer flips per REQ-023.
REQ-025 Without TL_ARB_RR_EN, arbitration SHALL be fixed-priority with in0 always winning, and the pointer register SHALL be absent.

Reset
REQ-026 While reset is high, the state SHALL be IDLE, the beat counter 0, and the pointer 0.
REQ-027 While reset is high, in0/in1_a_ready, out_a_valid, in0/in1_d_valid and out_d_ready SHALL all be forced to 0.
REQ-028 A reset asserted mid-burst SHALL abandon the burst, and the first post-reset cycle SHALL arbitrate afresh from IDLE.

Structure
REQ-029 Package tl_arb_pkg SHALL hold the opcode constants (PUT_FULL=0, PUT_PARTIAL=1, GET=4), the state enum, and a function beats_of(opcode,size).
REQ-030 One sub-module, tl_beat_counter (load, decrement, last-flag), SHALL be instantiated once; the arbitration and D-steering logic SHALL live in the top module.

Verification
REQ-031 Both inputs valid with single-beat Gets, out_a_ready=1, TL_ARB_RR_EN defined -> grants alternate 0,1,0,1 and source follows the grant.
REQ-032 Same stimulus without TL_ARB_RR_EN -> in0 is granted every cycle and in1_a_ready stays 0.
REQ-033 in0 PutFull size=6 (8 beats, DATA_W=64), with in1 valid throughout -> 8 consecutive in0 beats are sent and in1 is granted only on the 9th fire.
REQ-034 in0 valid while out_a_ready=0 for 3 cycles, with in1 asserting valid in cycle 2 -> out_a_bits are unchanged across all 3 cycles and in0 fires first.
REQ-035 out_d_valid=1 with source=1 and in1_d_ready=0 -> in1_d_valid=1, in0_d_valid=0, out_d_ready=0; raising in1_d_ready then completes the beat.
REQ-036 reset asserted at beat 3 of an 8-beat put -> all valids/readies are 0 during reset, and the next cycle re-arbitrates with pointer=0.

Source files
------------

// File: rtl/tl_arb_pkg.sv
// tl_arb_pkg
// Shared definitions for the two-requester TileLink A-channel arbiter:
// A-channel opcode constants, the arbiter state enum, the beat-counter
// width and beats_of(), which gives the number of data beats in a message.
// No ports (package).

package tl_arb_pkg;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET         = 3'd4;

    // Wide enough for 2^15 beats (size=15 on an 8-bit bus).
    localparam int BEAT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    // Only puts carry data on A, so only puts longer than one bus beat are
    // multi-beat.
    // lg_beat_bytes is log2 of the bus width in bytes (3 for a 64-bit bus).
    function automatic logic [BEAT_W-1:0] beats_of(
        input logic [2:0] opcode,
        input logic [3:0] size,
        input logic [3:0] lg_beat_bytes = 4'd3
    );
        logic [BEAT_W-1:0] b;
        b = BEAT_W'(1);
        if ((opcode == PUT_FULL || opcode == PUT_PARTIAL) && size > lg_beat_bytes) begin
            b = BEAT_W'(1) << (size - lg_beat_bytes);
        end
        return b;
    endfunction

endpackage

// File: rtl/tl_a_arbiter_if.sv
// tl_a_arbiter_if
// One TileLink link (A and D channels) with a 1-bit source field.
// Parameters: ADDR_W (address width), DATA_W (data width, mask is DATA_W/8).
// Modports:
//   master - drives A (valid/bits) and d_ready; receives a_ready and D.
//   slave  - receives A and d_ready; drives a_ready and D (valid/bits).

interface tl_a_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);

    logic                  a_ready;
    logic                  a_valid;
    logic [2:0]            a_bits_opcode;
    logic [3:0]            a_bits_size;
    logic [ADDR_W-1:0]     a_bits_address;
    logic [DATA_W/8-1:0]   a_bits_mask;
    logic [DATA_W-1:0]     a_bits_data;
    logic                  a_bits_source;

    logic                  d_ready;
    logic                  d_valid;
    logic [2:0]            d_bits_opcode;
    logic [1:0]            d_bits_param;
    logic [3:0]            d_bits_size;
    logic [2:0]            d_bits_sink;
    logic                  d_bits_denied;
    logic [DATA_W-1:0]     d_bits_data;
    logic                  d_bits_corrupt;
    logic                  d_bits_source;

    modport master (
        input  a_ready,
        output a_valid, a_bits_opcode, a_bits_size, a_bits_address,
               a_bits_mask, a_bits_data, a_bits_source,
        output d_ready,
        input  d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_sink,
               d_bits_denied, d_bits_data, d_bits_corrupt, d_bits_source
    );

    modport slave (
        output a_ready,
        input  a_valid, a_bits_opcode, a_bits_size, a_bits_address,
               a_bits_mask, a_bits_data, a_bits_source,
        input  d_ready,
        output d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_sink,
               d_bits_denied, d_bits_data, d_bits_corrupt, d_bits_source
    );

endinterface

// File: rtl/tl_beat_counter.sv
// tl_beat_counter
// Remaining-beat counter for the message that currently holds the A channel.
// Ports:
//   clock, reset    - clock, synchronous active-high reset (count -> 0)
//   load_i          - load load_val_i (beats still to send after the first)
//   load_val_i      - value to load
//   dec_i           - one beat was accepted
//   last_o          - the beat now on the bus is the final one (count == 1)

module tl_beat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         last_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == W'(1));

endmodule

// File: rtl/tl_a_arbiter.sv
// tl_a_arbiter
// Two-requester TileLink arbiter. The A channel is muxed combinationally
// from the granted requester onto out (zero latency); the grant is frozen
// while a beat is stalled (HOLD) and while a multi-beat put streams (BURST).
// The D channel is steered back by out.d_bits_source.
// Configuration macro: TL_ARB_RR_EN
//   defined   - round-robin; the pointer's input has priority and the
//               pointer moves to the loser on a message's final-beat fire.
//   undefined - fixed priority, in0 always wins; no pointer register.
// Parameters: ADDR_W (address width), DATA_W (data width).
// Ports:
//   clock, reset - clock, synchronous active-high reset
//   in0, in1     - requester links (slave modport: arbiter accepts A, returns D)
//   out          - link toward the slave (master modport); a_bits_source
//                  carries the grant index, d_bits_source selects the D target

module tl_a_arbiter
    import tl_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic           clock,
    input  logic           reset,
    tl_a_arbiter_if.slave  in0,
    tl_a_arbiter_if.slave  in1,
    tl_a_arbiter_if.master out
);

    localparam int LG_BYTES = $clog2(DATA_W / 8);

    arb_state_e          state_q, state_d;
    logic                grant_q, grant_d;
    logic                grant;
    logic                arb_pick;
    logic                fire;
    logic                last_fire;
    logic                cnt_load, cnt_dec, cnt_last;
    logic [BEAT_W-1:0]   msg_beats;
    logic [BEAT_W-1:0]   cnt_load_val;

    logic                sel_valid;
    logic [2:0]          sel_opcode;
    logic [3:0]          sel_size;
    logic [ADDR_W-1:0]   sel_address;
    logic [DATA_W/8-1:0] sel_mask;
    logic [DATA_W-1:0]   sel_data;

    // Requester-side source fields carry no meaning here; the arbiter
    // supplies its own source on out.
    logic unused_src;
    assign unused_src = in0.a_bits_source ^ in1.a_bits_source;

`ifdef TL_ARB_RR_EN
    logic ptr_q, ptr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_d = last_fire ? ~grant : ptr_q;

    // The pointer's input wins if valid; otherwise the other input if valid.
    always_comb begin
        arb_pick = ptr_q;
        if (!(ptr_q ? in1.a_valid : in0.a_valid) && (ptr_q ? in0.a_valid : in1.a_valid)) begin
            arb_pick = ~ptr_q;
        end
    end
`else
    always_comb begin
        arb_pick = !in0.a_valid && in1.a_valid;
    end

    // Message completion only matters to the round-robin pointer.
    logic unused_last;
    assign unused_last = last_fire;
`endif

    // Fresh arbitration only in IDLE; HOLD and BURST keep the latched grant.
    assign grant = (state_q == IDLE) ? arb_pick : grant_q;

    assign sel_valid   = grant ? in1.a_valid        : in0.a_valid;
    assign sel_opcode  = grant ? in1.a_bits_opcode  : in0.a_bits_opcode;
    assign sel_size    = grant ? in1.a_bits_size    : in0.a_bits_size;
    assign sel_address = grant ? in1.a_bits_address : in0.a_bits_address;
    assign sel_mask    = grant ? in1.a_bits_mask    : in0.a_bits_mask;
    assign sel_data    = grant ? in1.a_bits_data    : in0.a_bits_data;

    assign out.a_valid        = sel_valid & ~reset;
    assign out.a_bits_opcode  = sel_opcode;
    assign out.a_bits_size    = sel_size;
    assign out.a_bits_address = sel_address;
    assign out.a_bits_mask    = sel_mask;
    assign out.a_bits_data    = sel_data;
    assign out.a_bits_source  = grant;

    assign in0.a_ready = ~reset & ~grant & out.a_ready;
    assign in1.a_ready = ~reset &  grant & out.a_ready;

    assign fire      = out.a_valid & out.a_ready;
    assign msg_beats = beats_of(sel_opcode, sel_size, 4'(LG_BYTES));

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = msg_beats - BEAT_W'(1);
        last_fire    = 1'b0;
        unique case (state_q)
            IDLE, HOLD: begin
                if (fire) begin
                    if (msg_beats > BEAT_W'(1)) begin
                        state_d  = BURST;
                        cnt_load = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        last_fire = 1'b1;
                    end
                end else if (state_q == IDLE && sel_valid) begin
                    // Stalled first beat: freeze the grant so the offered
                    // beat cannot change under the slave.
                    state_d = HOLD;
                end
            end
            BURST: begin
                if (fire) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_d   = IDLE;
                        last_fire = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_d = grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    tl_beat_counter #(.W(BEAT_W)) u_beat_counter (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .last_o     (cnt_last)
    );

    // D channel: valid/ready steered by source, payload broadcast.
    assign in0.d_valid = ~reset & out.d_valid & ~out.d_bits_source;
    assign in1.d_valid = ~reset & out.d_valid &  out.d_bits_source;
    assign out.d_ready = ~reset & (out.d_bits_source ? in1.d_ready : in0.d_ready);

    assign in0.d_bits_opcode  = out.d_bits_opcode;
    assign in0.d_bits_param   = out.d_bits_param;
    assign in0.d_bits_size    = out.d_bits_size;
    assign in0.d_bits_sink    = out.d_bits_sink;
    assign in0.d_bits_denied  = out.d_bits_denied;
    assign in0.d_bits_data    = out.d_bits_data;
    assign in0.d_bits_corrupt = out.d_bits_corrupt;
    assign in0.d_bits_source  = out.d_bits_source;

    assign in1.d_bits_opcode  = out.d_bits_opcode;
    assign in1.d_bits_param   = out.d_bits_param;
    assign in1.d_bits_size    = out.d_bits_size;
    assign in1.d_bits_sink    = out.d_bits_sink;
    assign in1.d_bits_denied  = out.d_bits_denied;
    assign in1.d_bits_data    = out.d_bits_data;
    assign in1.d_bits_corrupt = out.d_bits_corrupt;
    assign in1.d_bits_source  = out.d_bits_source;

endmodule

// File: tb/tb_tl_a_arbiter.sv
// tb_tl_a_arbiter
// Bench for tl_a_arbiter: directed scenarios plus a randomized run checked
// against a message-level reference model (a requester owns the channel
// from its first offered beat until its last beat is accepted).

module tb_tl_a_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    tl_a_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) in0_if ();
    tl_a_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) in1_if ();
    tl_a_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) out_if ();

    tl_a_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .in0   (in0_if),
        .in1   (in1_if),
        .out   (out_if)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic int beats(input logic [2:0] op, input logic [3:0] sz);
        if ((op == OP_PUT_FULL || op == OP_PUT_PARTIAL) && sz > 4'd3) return 1 << (sz - 4'd3);
        return 1;
    endfunction

    task automatic drive_a(input int idx, input logic v, input logic [2:0] op,
                           input logic [3:0] sz, input logic [31:0] addr, input logic [63:0] data);
        if (idx == 0) begin
            in0_if.a_valid = v; in0_if.a_bits_opcode = op; in0_if.a_bits_size = sz;
            in0_if.a_bits_address = addr; in0_if.a_bits_data = data;
            in0_if.a_bits_mask = 8'hFF; in0_if.a_bits_source = 1'b0;
        end else begin
            in1_if.a_valid = v; in1_if.a_bits_opcode = op; in1_if.a_bits_size = sz;
            in1_if.a_bits_address = addr; in1_if.a_bits_data = data;
            in1_if.a_bits_mask = 8'hFF; in1_if.a_bits_source = 1'b0;
        end
    endtask

    task automatic idle_all();
        drive_a(0, 1'b0, OP_GET, 4'd0, 32'h0, 64'h0);
        drive_a(1, 1'b0, OP_GET, 4'd0, 32'h0, 64'h0);
        out_if.a_ready = 1'b0;
        in0_if.d_ready = 1'b0; in1_if.d_ready = 1'b0;
        out_if.d_valid = 1'b0; out_if.d_bits_opcode = 3'd0; out_if.d_bits_param = 2'd0;
        out_if.d_bits_size = 4'd0; out_if.d_bits_sink = 3'd0; out_if.d_bits_denied = 1'b0;
        out_if.d_bits_data = 64'h0; out_if.d_bits_corrupt = 1'b0; out_if.d_bits_source = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        idle_all();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        @(negedge clock);
        reset = 1'b1;
        drive_a(0, 1'b1, OP_GET, 4'd3, 32'h10, 64'h1);
        drive_a(1, 1'b1, OP_GET, 4'd3, 32'h20, 64'h2);
        out_if.a_ready = 1'b1; out_if.d_valid = 1'b1;
        in0_if.d_ready = 1'b1; in1_if.d_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            out_if.d_bits_source = s[0];
            @(negedge clock); #1;
            got = {in0_if.a_ready, in1_if.a_ready, out_if.a_valid,
                   in0_if.d_valid, in1_if.d_valid, out_if.d_ready};
            checks++;
            if (got !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs src=%0d: got %b want 000000", s, got);
            end
        end
        // First cycle out of reset arbitrates from IDLE: only in1 offers.
        @(negedge clock);
        idle_all();
        reset = 1'b0;
        drive_a(1, 1'b1, OP_GET, 4'd3, 32'h20, 64'h2);
        #1;
        checks++;
        if (out_if.a_valid !== 1'b1 || out_if.a_bits_source !== 1'b1 || out_if.a_bits_address !== 32'h20) begin
            errors++;
            $display("FAIL reset_first_grant: valid=%b src=%b addr=%h want 1 1 00000020",
                     out_if.a_valid, out_if.a_bits_source, out_if.a_bits_address);
        end
    endtask

    task automatic test_alternate();
        logic exp;
        do_reset();
        @(negedge clock);
        drive_a(0, 1'b1, OP_GET, 4'd3, 32'hA0, 64'h0);
        drive_a(1, 1'b1, OP_GET, 4'd3, 32'hB0, 64'h0);
        out_if.a_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clock);
            #1;
`ifdef TL_ARB_RR_EN
            exp = i[0];
`else
            exp = 1'b0;
`endif
            checks++;
            if (out_if.a_bits_source !== exp || out_if.a_valid !== 1'b1) begin
                errors++;
                $display("FAIL alt_grant cycle %0d: src=%b valid=%b want src=%b valid=1",
                         i, out_if.a_bits_source, out_if.a_valid, exp);
            end
            checks++;
            if (in1_if.a_ready !== exp || in0_if.a_ready !== ~exp) begin
                errors++;
                $display("FAIL alt_ready cycle %0d: r0=%b r1=%b want r0=%b r1=%b",
                         i, in0_if.a_ready, in1_if.a_ready, ~exp, exp);
            end
            checks++;
            if (out_if.a_bits_address !== (exp ? 32'hB0 : 32'hA0)) begin
                errors++;
                $display("FAIL alt_addr cycle %0d: got %h want %h", i, out_if.a_bits_address,
                         exp ? 32'hB0 : 32'hA0);
            end
        end
    endtask

    task automatic test_burst();
        int fires;
        int sent0;
        logic exp;
        do_reset();
        drive_a(1, 1'b1, OP_GET, 4'd3, 32'hB0, 64'h0);
        out_if.a_ready = 1'b1;
        fires = 0; sent0 = 0;
        for (int cyc = 0; cyc < 30 && fires < 9; cyc++) begin
            @(negedge clock);
            if (sent0 < 8) drive_a(0, 1'b1, OP_PUT_FULL, 4'd6, 32'h1000, 64'hA000 + 64'(sent0));
            else           drive_a(0, 1'b0, OP_PUT_FULL, 4'd6, 32'h1000, 64'h0);
            #1;
            if (out_if.a_valid && out_if.a_ready) begin
                fires++;
                exp = (fires > 8);
                checks++;
                if (out_if.a_bits_source !== exp) begin
                    errors++;
                    $display("FAIL burst_src fire %0d: got %b want %b", fires, out_if.a_bits_source, exp);
                end
                if (fires <= 8) begin
                    checks++;
                    if (out_if.a_bits_data !== 64'hA000 + 64'(sent0) || in1_if.a_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL burst_beat fire %0d: data=%h r1=%b want %h 0", fires,
                                 out_if.a_bits_data, in1_if.a_ready, 64'hA000 + 64'(sent0));
                    end
                end
                if (out_if.a_bits_source == 1'b0) sent0++;
            end
        end
        checks++;
        if (fires != 9) begin
            errors++;
            $display("FAIL burst_fire_count: got %0d want 9", fires);
        end
    endtask

    task automatic test_hold();
        do_reset();
        // One in0 Get first, so a round-robin pointer would favour in1.
        @(negedge clock);
        drive_a(0, 1'b1, OP_GET, 4'd3, 32'h0, 64'h0);
        out_if.a_ready = 1'b1;
        @(negedge clock);
        drive_a(0, 1'b1, OP_GET, 4'd2, 32'h5555, 64'h1111);
        out_if.a_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) @(negedge clock);
            if (c == 1) drive_a(1, 1'b1, OP_GET, 4'd2, 32'h7777, 64'h2222);
            #1;
            checks++;
            if (out_if.a_valid !== 1'b1 || out_if.a_bits_source !== 1'b0 ||
                out_if.a_bits_address !== 32'h5555 || out_if.a_bits_data !== 64'h1111) begin
                errors++;
                $display("FAIL hold_stable cycle %0d: v=%b src=%b addr=%h data=%h want 1 0 5555 1111",
                         c, out_if.a_valid, out_if.a_bits_source, out_if.a_bits_address, out_if.a_bits_data);
            end
        end
        @(negedge clock);
        out_if.a_ready = 1'b1;
        #1;
        checks++;
        if (in0_if.a_ready !== 1'b1 || in1_if.a_ready !== 1'b0 || out_if.a_bits_source !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: r0=%b r1=%b src=%b want 1 0 0",
                     in0_if.a_ready, in1_if.a_ready, out_if.a_bits_source);
        end
        @(negedge clock);
        drive_a(0, 1'b0, OP_GET, 4'd2, 32'h0, 64'h0);
        #1;
        checks++;
        if (out_if.a_bits_source !== 1'b1 || out_if.a_bits_address !== 32'h7777) begin
            errors++;
            $display("FAIL hold_next: src=%b addr=%h want 1 7777", out_if.a_bits_source, out_if.a_bits_address);
        end
    endtask

    task automatic test_d_route();
        @(negedge clock);
        idle_all();
        out_if.d_valid = 1'b1; out_if.d_bits_source = 1'b1; out_if.d_bits_data = 64'hDEAD_BEEF_0123_4567;
        in0_if.d_ready = 1'b1; in1_if.d_ready = 1'b0;
        #1;
        checks++;
        if (in1_if.d_valid !== 1'b1 || in0_if.d_valid !== 1'b0 || out_if.d_ready !== 1'b0) begin
            errors++;
            $display("FAIL d_steer1: v0=%b v1=%b rdy=%b want 0 1 0", in0_if.d_valid, in1_if.d_valid, out_if.d_ready);
        end
        checks++;
        if (in0_if.d_bits_data !== 64'hDEAD_BEEF_0123_4567 || in1_if.d_bits_data !== 64'hDEAD_BEEF_0123_4567) begin
            errors++;
            $display("FAIL d_broadcast: d0=%h d1=%h want deadbeef01234567", in0_if.d_bits_data, in1_if.d_bits_data);
        end
        @(negedge clock);
        in1_if.d_ready = 1'b1;
        #1;
        checks++;
        if (out_if.d_ready !== 1'b1) begin
            errors++;
            $display("FAIL d_complete: rdy=%b want 1", out_if.d_ready);
        end
        @(negedge clock);
        out_if.d_bits_source = 1'b0; in0_if.d_ready = 1'b0;
        #1;
        checks++;
        if (in0_if.d_valid !== 1'b1 || in1_if.d_valid !== 1'b0 || out_if.d_ready !== 1'b0) begin
            errors++;
            $display("FAIL d_steer0: v0=%b v1=%b rdy=%b want 1 0 0", in0_if.d_valid, in1_if.d_valid, out_if.d_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        int fires;
        logic [4:0] got;
        do_reset();
        @(negedge clock);
        drive_a(0, 1'b1, OP_GET, 4'd3, 32'h0, 64'h0);
        out_if.a_ready = 1'b1;
        @(negedge clock);
        drive_a(0, 1'b0, OP_GET, 4'd3, 32'h0, 64'h0);
        drive_a(1, 1'b1, OP_PUT_FULL, 4'd6, 32'h2000, 64'hB0);
        fires = 0;
        #1;
        if (out_if.a_valid && out_if.a_ready) fires++;
        for (int cyc = 0; cyc < 20 && fires < 3; cyc++) begin
            @(negedge clock); #1;
            if (out_if.a_valid && out_if.a_ready) fires++;
        end
        checks++;
        if (fires != 3) begin
            errors++;
            $display("FAIL rmb_fires: got %0d want 3", fires);
        end
        @(negedge clock);
        reset = 1'b1;
        drive_a(0, 1'b1, OP_GET, 4'd3, 32'h3000, 64'hC0);
        out_if.d_valid = 1'b1; in0_if.d_ready = 1'b1; in1_if.d_ready = 1'b1;
        #1;
        got = {in0_if.a_ready, in1_if.a_ready, out_if.a_valid, in0_if.d_valid, out_if.d_ready};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL rmb_reset_outputs: got %b want 00000", got);
        end
        @(negedge clock);
        reset = 1'b0;
        out_if.d_valid = 1'b0;
        drive_a(1, 1'b1, OP_GET, 4'd3, 32'h4000, 64'hD0);
        #1;
        checks++;
        if (out_if.a_valid !== 1'b1 || out_if.a_bits_source !== 1'b0 || in0_if.a_ready !== 1'b1 ||
            out_if.a_bits_address !== 32'h3000) begin
            errors++;
            $display("FAIL rmb_rearb: v=%b src=%b r0=%b addr=%h want 1 0 1 3000",
                     out_if.a_valid, out_if.a_bits_source, in0_if.a_ready, out_if.a_bits_address);
        end
    endtask

    task automatic test_random();
        logic        act [2];
        logic [2:0]  op  [2];
        logic [3:0]  sz  [2];
        logic [31:0] ad  [2];
        logic [63:0] dt  [2];
        int          rem [2];
        int          own, mptr, g;
        logic        rdy, dv, ds, dr0, dr1;
        logic [63:0] dd;
        do_reset();
        own = -1; mptr = 0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; rem[i] = 0; op[i] = OP_GET; sz[i] = 4'd0; ad[i] = 32'h0; dt[i] = 64'h0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && $urandom_range(1, 0) == 1) begin
                    case ($urandom_range(2, 0))
                        0:       op[i] = OP_PUT_FULL;
                        1:       op[i] = OP_PUT_PARTIAL;
                        default: op[i] = OP_GET;
                    endcase
                    sz[i] = 4'($urandom_range(6, 0));
                    ad[i] = $urandom;
                    dt[i] = {$urandom, $urandom};
                    rem[i] = beats(op[i], sz[i]);
                    act[i] = 1'b1;
                end
                drive_a(i, act[i], op[i], sz[i], ad[i], dt[i]);
            end
            rdy = ($urandom_range(3, 0) != 0);
            out_if.a_ready = rdy;
            dv = $urandom_range(1, 0) == 1; ds = $urandom_range(1, 0) == 1;
            dr0 = $urandom_range(1, 0) == 1; dr1 = $urandom_range(1, 0) == 1;
            dd = {$urandom, $urandom};
            out_if.d_valid = dv; out_if.d_bits_source = ds; out_if.d_bits_data = dd;
            out_if.d_bits_sink = 3'($urandom_range(7, 0));
            in0_if.d_ready = dr0; in1_if.d_ready = dr1;
            #1;
            if (own >= 0) g = own;
`ifdef TL_ARB_RR_EN
            else g = act[mptr] ? mptr : (act[1-mptr] ? 1 - mptr : -1);
`else
            else g = act[0] ? 0 : (act[1] ? 1 : -1);
`endif
            checks++;
            if (out_if.a_valid !== (g >= 0)) begin
                errors++;
                $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, out_if.a_valid, g >= 0);
            end
            if (g >= 0) begin
                checks++;
                if (out_if.a_bits_source !== g[0] || out_if.a_bits_address !== ad[g] ||
                    out_if.a_bits_data !== dt[g] || out_if.a_bits_opcode !== op[g] || out_if.a_bits_size !== sz[g]) begin
                    errors++;
                    $display("FAIL rnd_bits cyc %0d: src=%b addr=%h data=%h want src=%0d addr=%h data=%h",
                             cyc, out_if.a_bits_source, out_if.a_bits_address, out_if.a_bits_data, g, ad[g], dt[g]);
                end
                checks++;
                if ((g == 0 ? in0_if.a_ready : in1_if.a_ready) !== rdy ||
                    (g == 0 ? in1_if.a_ready : in0_if.a_ready) !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_ready cyc %0d: r0=%b r1=%b grant=%0d out_ready=%b",
                             cyc, in0_if.a_ready, in1_if.a_ready, g, rdy);
                end
            end
            checks++;
            if (in0_if.d_valid !== (dv & ~ds) || in1_if.d_valid !== (dv & ds) ||
                out_if.d_ready !== (ds ? dr1 : dr0) || in0_if.d_bits_data !== dd || in1_if.d_bits_data !== dd) begin
                errors++;
                $display("FAIL rnd_d cyc %0d: v0=%b v1=%b rdy=%b want %b %b %b", cyc,
                         in0_if.d_valid, in1_if.d_valid, out_if.d_ready, dv & ~ds, dv & ds, ds ? dr1 : dr0);
            end
            // Reference update: the offering requester owns the channel until
            // its last beat is accepted.
            if (g >= 0) begin
                if (rdy) begin
                    rem[g]--;
                    dt[g] = {$urandom, $urandom};
                    if (rem[g] == 0) begin
                        act[g] = 1'b0;
                        own = -1;
                        mptr = 1 - g;
                    end else begin
                        own = g;
                    end
                end else begin
                    own = g;
                end
            end
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_alternate();
        test_burst();
        test_hold();
        test_d_route();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
